// File: rtl/cnn_layer_sequencer.sv
// Autonomous conv1/pool1/conv2/pool2/FC layer sequencer with registered control outputs.
// Optional per-layer watchdog and ERROR state compiled in with `define CNN_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] layer_done,
    output logic [4:0] layer_en,
    output logic [4:0] layer_mem_reset,
    output logic       MAC_enable,
    output logic       rMAC,
    output logic [1:0] MAC_layer,
    output logic       pooling_layer,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DONE
`ifdef CNN_SEQ_TIMEOUT_EN
        , S_ERROR
`endif
    } state_t;

    typedef struct packed {
        logic [4:0] en;
        logic [4:0] mem_rst;
        logic       mac_en;
        logic       rmac;
        logic [1:0] mac_layer;
        logic       pool;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] status;
    } outs_t;

    state_t     state;
    logic [2:0] layer;
    logic [3:0] settle_cnt;
    outs_t      outs;

    // Output image of a state; the FSM loads it alongside the state so every output is a flop.
    function automatic outs_t decode(input state_t s, input logic [2:0] lk);
        outs_t o;
        logic  run;
        logic  mac;
        run         = (s == S_RUN);
        mac         = run && !lk[0];
        o.en        = run ? (5'b00001 << lk) : 5'b00000;
        o.mem_rst   = ~o.en;
        o.mac_en    = mac;
        o.rmac      = ~mac;
        o.mac_layer = mac ? lk[2:1] : 2'b00;
        o.pool      = run && lk[0];
        o.busy      = (s == S_PREP) || run;
        o.done      = (s == S_DONE);
        o.err       = 1'b0;
        case (s)
            S_PREP, S_RUN: o.status = {5'd0, lk} + 8'd1;
            S_DONE:        o.status = 8'd6;
`ifdef CNN_SEQ_TIMEOUT_EN
            S_ERROR: begin
                o.status = 8'h80 | {5'd0, lk};
                o.err    = 1'b1;
            end
`endif
            default:       o.status = 8'd0;
        endcase
        return o;
    endfunction

`ifdef CNN_SEQ_TIMEOUT_EN
    logic [20:0] wd_cnt;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            layer      <= 3'd0;
            settle_cnt <= 4'd0;
`ifdef CNN_SEQ_TIMEOUT_EN
            wd_cnt     <= 21'd0;
`endif
            outs       <= decode(S_IDLE, 3'd0);
        end else if (abort) begin
            state <= S_IDLE;
            layer <= 3'd0;
            outs  <= decode(S_IDLE, 3'd0);
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_PREP;
                        layer      <= 3'd0;
                        settle_cnt <= 4'd1;
                        outs       <= decode(S_PREP, 3'd0);
                    end
                end
                // layer_done is deliberately not looked at here: flags are stale during reset.
                S_PREP: begin
                    if (settle_cnt == 4'(SETTLE_CYCLES)) begin
                        state <= S_RUN;
`ifdef CNN_SEQ_TIMEOUT_EN
                        wd_cnt <= 21'd0;
`endif
                        outs  <= decode(S_RUN, layer);
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                S_RUN: begin
                    if (layer_done[layer]) begin
                        if (layer == 3'd4) begin
                            state <= S_DONE;
                            outs  <= decode(S_DONE, layer);
                        end else begin
                            state      <= S_PREP;
                            layer      <= layer + 3'd1;
                            settle_cnt <= 4'd1;
                            outs       <= decode(S_PREP, layer + 3'd1);
                        end
                    end
`ifdef CNN_SEQ_TIMEOUT_EN
                    else if (wd_cnt == 21'(TIMEOUT_CYCLES - 1)) begin
                        state <= S_ERROR;
                        outs  <= decode(S_ERROR, layer);
                    end else begin
                        wd_cnt <= wd_cnt + 21'd1;
                    end
`endif
                end
`ifdef CNN_SEQ_TIMEOUT_EN
                S_ERROR: ;
`endif
                default: begin
                    state <= S_IDLE;
                    layer <= 3'd0;
                    outs  <= decode(S_IDLE, 3'd0);
                end
            endcase
        end
    end

    assign layer_en        = outs.en;
    assign layer_mem_reset = outs.mem_rst;
    assign MAC_enable      = outs.mac_en;
    assign rMAC            = outs.rmac;
    assign MAC_layer       = outs.mac_layer;
    assign pooling_layer   = outs.pool;
    assign busy            = outs.busy;
    assign done            = outs.done;
    assign error           = outs.err;
    assign status          = outs.status;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed table, corner sequences and random traffic
// checked every cycle against a phase/age model of the layer walk.
module tb_cnn_layer_sequencer;

    localparam int SETTLE = 2;
    localparam int TOUT   = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] layer_done = 5'd0;
    logic [4:0] layer_en, layer_mem_reset;
    logic       MAC_enable, rMAC, pooling_layer, busy, done, error;
    logic [1:0] MAC_layer;
    logic [7:0] status;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .layer_done(layer_done), .layer_en(layer_en), .layer_mem_reset(layer_mem_reset),
        .MAC_enable(MAC_enable), .rMAC(rMAC), .MAC_layer(MAC_layer),
        .pooling_layer(pooling_layer), .busy(busy), .done(done), .error(error),
        .status(status)
    );

    logic [25:0] act;
    assign act = {layer_en, layer_mem_reset, MAC_enable, rMAC, MAC_layer,
                  pooling_layer, busy, done, error, status};

    localparam logic [25:0] RST_WORD = {5'd0, 5'h1f, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 prep, 2 run, 3 done, 4 error; age = cycles completed in phase.
    int m_mode = 0, m_layer = 0, m_age = 0;

    function automatic logic [25:0] exp_word();
        logic [4:0] en;
        logic       run, mac, pool;
        logic [1:0] ml;
        logic [7:0] st;
        run  = (m_mode == 2);
        en   = run ? 5'(1 << m_layer) : 5'd0;
        mac  = run && (m_layer % 2 == 0);
        pool = run && (m_layer % 2 == 1);
        ml   = mac ? 2'(m_layer / 2) : 2'd0;
        case (m_mode)
            0:       st = 8'd0;
            1, 2:    st = 8'(m_layer + 1);
            3:       st = 8'd6;
            default: st = 8'(128 + m_layer);
        endcase
        return {en, 5'h1f ^ en, mac, !mac, ml, pool, (m_mode == 1 || m_mode == 2),
                (m_mode == 3), (m_mode == 4), st};
    endfunction

    task automatic model_step(input logic s, input logic a, input logic [4:0] l);
        if (a) begin
            m_mode = 0;
            m_age  = 0;
        end else begin
            case (m_mode)
                0, 3: if (s) begin m_mode = 1; m_layer = 0; m_age = 0; end
                1: begin
                    if (m_age + 1 >= SETTLE) begin m_mode = 2; m_age = 0; end
                    else m_age++;
                end
                2: begin
                    if (l[m_layer]) begin
                        if (m_layer == 4) m_mode = 3;
                        else begin m_layer++; m_mode = 1; end
                        m_age = 0;
                    end else begin
                        m_age++;
`ifdef CNN_SEQ_TIMEOUT_EN
                        if (m_age == TOUT) m_mode = 4;
`endif
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, a, e, $time);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic [4:0] l);
        start = s;
        abort = a;
        layer_done = l;
        @(posedge clk);
        model_step(s, a, l);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("cycle", 32'(act), 32'(exp_word()));
    endtask

    task automatic drive_to(input int tm, input int tl);
        int n = 0;
        while (!(m_mode == tm && m_layer == tl) && n < 300) begin
            step(1'b0, 1'b0, (m_mode == 2 && m_layer < tl) ? 5'(1 << m_layer) : 5'd0);
            n++;
        end
        check("drive_to_budget", 32'(n < 300), 32'd1);
    endtask

    typedef struct {
        logic       st;
        logic       ab;
        logic [4:0] ld;
        logic [7:0] status;
        logic [4:0] en;
        logic       busy;
        logic       done;
    } vec_t;
    vec_t tbl[18];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, prev;
        #7;
        check("reset_model", 32'(act), 32'(exp_word()));
        check("reset_const", 32'(act), 32'(RST_WORD));
        @(negedge clk);
        reset_n = 1'b1;

        // Stale all-ones done flags: 2 PREP + 1 RUN per layer, then rerun and abort.
        tbl[0]  = '{1'b1, 1'b0, 5'h1f, 8'd1, 5'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 5'h1f, 8'd1, 5'h00, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 5'h1f, 8'd1, 5'h01, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 5'h1f, 8'd2, 5'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 5'h1f, 8'd2, 5'h00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 5'h1f, 8'd2, 5'h02, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'h1f, 8'd3, 5'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 5'h1f, 8'd3, 5'h00, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 5'h1f, 8'd3, 5'h04, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 5'h1f, 8'd4, 5'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 5'h1f, 8'd4, 5'h00, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 5'h1f, 8'd4, 5'h08, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 5'h1f, 8'd5, 5'h00, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 5'h1f, 8'd5, 5'h00, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 5'h1f, 8'd5, 5'h10, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 5'h1f, 8'd6, 5'h00, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b0, 5'h1f, 8'd1, 5'h00, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 5'h1f, 8'd0, 5'h00, 1'b0, 1'b0};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].st, tbl[i].ab, tbl[i].ld);
            check("tbl_status", 32'(status), 32'(tbl[i].status));
            check("tbl_en", 32'(layer_en), 32'(tbl[i].en));
            check("tbl_busy_done", 32'({busy, done}), 32'({tbl[i].busy, tbl[i].done}));
        end

        // Each layer_done raised 10 cycles into RUN: 5 x (3+10) cycles to DONE.
        step(1'b1, 1'b0, 5'd0);
        n = 0;
        prev = 1;
        while (!done && n < 200) begin
            step(1'b0, 1'b0, (m_mode == 2 && m_age == 10) ? 5'(1 << m_layer) : 5'd0);
            n++;
            if (int'(status) != prev) begin
                check("status_seq", 32'(status), 32'(prev + 1));
                prev = int'(status);
            end
            if (MAC_enable) check("mac_layer", 32'(MAC_layer), 32'(m_layer / 2));
        end
        check("done_latency", 32'(n), 32'd65);
        check("final_status", 32'(status), 32'd6);

        // abort collides with layer_done[2] in RUN(2).
        step(1'b1, 1'b0, 5'd0);
        drive_to(2, 2);
        step(1'b0, 1'b1, 5'b00100);
        check("abort_status", 32'(status), 32'd0);
        check("abort_memrst", 32'(layer_mem_reset), 32'h1f);
        check("abort_busy", 32'(busy), 32'd0);

        // start during RUN(1) is ignored.
        step(1'b1, 1'b0, 5'd0);
        drive_to(2, 1);
        step(1'b1, 1'b0, 5'd0);
        check("start_in_run", 32'({busy, status, layer_en}), 32'({1'b1, 8'd2, 5'h02}));

        // Asynchronous reset in RUN(4), observed before any clock edge.
        drive_to(2, 4);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 32'(act), 32'(RST_WORD));
        m_mode = 0; m_layer = 0; m_age = 0;
        @(negedge clk);
        check("reset_hold", 32'(act), 32'(RST_WORD));
        reset_n = 1'b1;

`ifdef CNN_SEQ_TIMEOUT_EN
        step(1'b1, 1'b0, 5'd0);
        drive_to(2, 3);
        repeat (TOUT) step(1'b0, 1'b0, 5'd0);
        check("wd_error", 32'({error, status}), 32'({1'b1, 8'h83}));
        step(1'b1, 1'b0, 5'd0);
        check("wd_start_ignored", 32'({error, status}), 32'({1'b1, 8'h83}));
        step(1'b0, 1'b1, 5'd0);
        check("wd_abort", 32'(act), 32'(RST_WORD));
`endif

        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) == 0, ($urandom % 64) == 0, 5'($urandom & $urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Autonomous layer sequencer for the digit-recognition CNN accelerator. Software sets one `start` bit after the image is loaded, instead of stepping an 8-bit control code per layer. The block then walks conv1, pool1, conv2, pool2 and FC in order. For each layer it holds the layer's memory address generators in reset for a settle window, enables the MAC or pooling datapath, and waits for that layer's completion flag. It reports progress in the same 0–6 status encoding software already polls, and flags a hung layer through an optional watchdog.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles that a layer's memory resets and `rMAC` are held before the layer runs; legal range 1–15.
- `TIMEOUT_CYCLES`, default 2^20: maximum RUN cycles per layer before error; used only with the watchdog compiled in.

Ports:
- `clk`, input, 1: single system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse; accepted only in IDLE or DONE.
- `abort`, input, 1: one-cycle pulse; returns the sequencer to IDLE from any state.
- `layer_done`, input, 5: per-layer completion flags, produced externally by ANDing each layer's read/write done flags. Bit 0 = conv1, 1 = pool1, 2 = conv2, 3 = pool2, 4 = FC.
- `layer_en`, output, 5: one-hot layer select; same bit map as `layer_done`; asserted in RUN only.
- `layer_mem_reset`, output, 5: per-layer memory address reset; 1 = held in reset.
- `MAC_enable`, output, 1: MAC datapath enable.
- `rMAC`, output, 1: MAC accumulator reset; 1 = held clear.
- `MAC_layer`, output, 2: MAC layer select; 00 = conv1, 01 = conv2, 10 = FC.
- `pooling_layer`, output, 1: pooling datapath enable.
- `busy`, output, 1: high in PREP and RUN.
- `done`, output, 1: high in DONE.
- `error`, output, 1: high in ERROR.
- `status`, output, 8: progress code readable by software.

## Operation
- States:
  - IDLE, DONE and ERROR are the three rest states.
  - PREP(k) and RUN(k) exist for k = 0..4; k is the layer index.
- IDLE --start--> PREP(0). In the same transition `status` becomes 1 (image loaded).
- PREP(k): this state sets the following outputs.
  - `layer_mem_reset[k]`=1 and `rMAC`=1.
  - `layer_en`=0, `MAC_enable`=0 and `pooling_layer`=0.
  - A 4-bit settle counter counts `SETTLE_CYCLES`, then the FSM moves to RUN(k).
  - `layer_done` is ignored in PREP, because done flags are stale until the generators leave reset.
- RUN(k): this state sets the following outputs.
  - `layer_mem_reset[k]`=0 and `layer_en[k]`=1.
  - k in {0,2,4}: `MAC_enable`=1 and `rMAC`=0; `MAC_layer` = 00, 01 or 10 respectively.
  - k in {1,3}: `pooling_layer`=1 and `rMAC`=1.
  - When `layer_done[k]`=1, `status` becomes k+2. The FSM then moves to PREP(k+1), or to DONE when k=4.
  - Only bit k of `layer_done` is observed; all other bits are ignored.
- All `layer_mem_reset` bits other than the active layer's bit are 1 in every state.
- DONE: `status`=6 and `done`=1. The sequencer stays in DONE until `start` (rerun, to PREP(0) with `status`=1) or `abort` (to IDLE).
- ERROR: this state is reachable only with the watchdog compiled in.
  - `status` = 0x80 | k, where k is the layer that timed out.
  - All datapath enables are 0 and all `layer_mem_reset` bits are 1.
  - The FSM leaves ERROR only on `abort` or `reset_n`; `start` is ignored.
- `abort` takes priority over `start` and `layer_done` in the same cycle. The next state is IDLE and `status`=0.
- `start` is ignored while `busy` is high.

## Timing
- All outputs are registered; no combinational path exists from any input to any output.
- Reset values:
  - FSM state is IDLE.
  - `layer_en`=0, `MAC_enable`=0, `MAC_layer`=00, `pooling_layer`=0.
  - `rMAC`=1 and `layer_mem_reset`=5'b11111.
  - `busy`=0, `done`=0, `error`=0, `status`=0.
- Latency from a `start` pulse in cycle t:
  - `busy`=1 and `status`=1 in cycle t+1.
  - `layer_en[0]`=1 in cycle t+1+`SETTLE_CYCLES`.
- A layer's completion flag sampled high at edge t drives these outputs at t+1:
  - `layer_en[k]` goes to 0 and `layer_mem_reset[k]` returns to 1.
  - The next layer's PREP begins.
- Total overhead beyond the datapath time is 5×(`SETTLE_CYCLES`+1) cycles.
- Asserting `reset_n` low mid-run forces every output to its reset value asynchronously. No partial status is retained.

## Configuration
- The macro `CNN_SEQ_TIMEOUT_EN` selects the watchdog.
- Defined:
  - A 21-bit watchdog counter clears on entry to RUN(k) and increments each RUN cycle.
  - When the counter reaches `TIMEOUT_CYCLES` without `layer_done[k]`, the next state is ERROR.
  - If `layer_done[k]` is high in the same cycle the count is reached, the done flag wins.
- Undefined:
  - No counter or ERROR state is synthesized, and `error` is tied to 0.
  - RUN(k) waits indefinitely; only `abort` or `reset_n` can exit.

## Test plan
- Reset, then `start` with `SETTLE_CYCLES`=2 and each `layer_done[k]` raised 10 cycles into RUN(k) → `status` reads 1,2,3,4,5,6 in order; `MAC_layer` reads 00, 01, 10 during the MAC layers; `done`=1 after 5×(3+10) cycles.
- `layer_done`=5'b11111 held high from before `start` → each layer still spends exactly 2 PREP cycles and 1 RUN cycle; stale flags never skip a layer.
- `abort` asserted in the same cycle as `layer_done[2]` during RUN(2) → IDLE, `status`=0 and `layer_mem_reset`=5'b11111 on the next cycle.
- `start` pulsed during RUN(1) → ignored; in DONE, `start` → PREP(0) and `status`=1.
- `CNN_SEQ_TIMEOUT_EN` defined, `TIMEOUT_CYCLES`=64, `layer_done[3]` never raised → `error`=1 and `status`=0x83 after 64 RUN cycles; `start` is ignored, then `abort` returns to IDLE.
- `reset_n` pulsed low during RUN(4) → all outputs take their reset values immediately, without waiting for a `clk` edge.
